// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Control and address bundle for the program-counter sequencer.
//   master : the control side (decode / testbench); drives the select
//            controls and targets, and observes PC, NextPC and the stack flags.
//   slave  : the sequencer itself.
//   Signals:
//     EN_L      active-low advance enable (1 = stall)
//     BR_TAKE   take relative branch
//     BR_OFF    signed branch offset relative to PC
//     JMP       absolute jump
//     JMP_ADDR  jump / call target
//     CALL      call: push PC+1, go to JMP_ADDR
//     RET       return: pop the stack into PC
//     PC        current fetch address (registered)
//     NextPC    address PC takes at the next rising edge
//     STK_FULL  return-address stack full
//     STK_EMPTY return-address stack empty
//     STK_ERR   sticky overflow/underflow flag
interface pc_sequencer_if #(
    parameter int PC_W = 8
);
    logic            EN_L;
    logic            BR_TAKE;
    logic [PC_W-1:0] BR_OFF;
    logic            JMP;
    logic [PC_W-1:0] JMP_ADDR;
    logic            CALL;
    logic            RET;
    logic [PC_W-1:0] PC;
    logic [PC_W-1:0] NextPC;
    logic            STK_FULL;
    logic            STK_EMPTY;
    logic            STK_ERR;

    modport master (
        output EN_L, BR_TAKE, BR_OFF, JMP, JMP_ADDR, CALL, RET,
        input  PC, NextPC, STK_FULL, STK_EMPTY, STK_ERR
    );

    modport slave (
        input  EN_L, BR_TAKE, BR_OFF, JMP, JMP_ADDR, CALL, RET,
        output PC, NextPC, STK_FULL, STK_EMPTY, STK_ERR
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Parametrised program-counter sequencer. Each enabled cycle the next
//   fetch address is chosen from (highest priority first) return, call,
//   jump, relative branch, increment. All arithmetic wraps modulo 2^PC_W.
//
//   Optional feature macro: PC_RAS_EN
//     defined   : circular return-address stack of RAS_DEPTH entries;
//                 pushing when full overwrites the oldest entry, popping
//                 when empty falls back to PC+1; both set sticky STK_ERR.
//     undefined : no stack; CALL acts as JMP, RET acts as increment,
//                 STK_FULL=0, STK_EMPTY=1, STK_ERR=0.
//
//   Ports:
//     CLK      rising-edge clock
//     RESET_L  asynchronous active-low reset (PC <= RESET_VEC, stack empty)
//     bus      pc_sequencer_if.slave (controls in; PC, NextPC, flags out)
module pc_sequencer #(
    parameter int              PC_W      = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input logic           CLK,
    input logic           RESET_L,
    pc_sequencer_if.slave bus
);

    if (PC_W < 4) begin : gBadWidth
        $error("pc_sequencer: PC_W must be >= 4");
    end
    if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : gBadDepth
        $error("pc_sequencer: RAS_DEPTH must be a power of two >= 2");
    end

    logic [PC_W-1:0] pcReg;
    logic [PC_W-1:0] nextPc;
    logic [PC_W-1:0] pcPlus1;
    logic [PC_W-1:0] pcBranch;

    assign pcPlus1  = pcReg + PC_W'(1);
    assign pcBranch = pcReg + bus.BR_OFF;

`ifdef PC_RAS_EN
    localparam int              PTR_W   = $clog2(RAS_DEPTH);
    localparam int              CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  stack [RAS_DEPTH];
    // wrPtr is the next free slot; when full it also points at the oldest
    // entry, so a push-when-full naturally overwrites the oldest.
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] topPtr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic             doPush;
    logic             doPop;
    logic             pushFull;
    logic             popEmpty;
    logic             fullReg;
    logic             emptyReg;
    logic             errReg;

    assign topPtr = wrPtr - PTR_W'(1);

    // RET outranks CALL, so a simultaneous CALL never pushes.
    always_comb begin
        doPush    = 1'b0;
        doPop     = 1'b0;
        pushFull  = 1'b0;
        popEmpty  = 1'b0;
        countNext = count;
        if (!bus.EN_L) begin
            if (bus.RET) begin
                if (count != '0) begin
                    doPop     = 1'b1;
                    countNext = count - CNT_W'(1);
                end else begin
                    popEmpty = 1'b1;
                end
            end else if (bus.CALL) begin
                doPush = 1'b1;
                if (count == CNT_MAX) begin
                    pushFull = 1'b1;
                end else begin
                    countNext = count + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        nextPc = pcPlus1;
        if (bus.EN_L) begin
            nextPc = pcReg;
        end else if (bus.RET) begin
            nextPc = (count != '0) ? stack[topPtr] : pcPlus1;
        end else if (bus.CALL || bus.JMP) begin
            nextPc = bus.JMP_ADDR;
        end else if (bus.BR_TAKE) begin
            nextPc = pcBranch;
        end
    end

    // Stack contents are deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (doPush) begin
            stack[wrPtr] <= pcPlus1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            wrPtr    <= '0;
            count    <= '0;
            fullReg  <= 1'b0;
            emptyReg <= 1'b1;
            errReg   <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end else if (doPop) begin
                wrPtr <= topPtr;
            end
            count    <= countNext;
            fullReg  <= (countNext == CNT_MAX);
            emptyReg <= (countNext == '0);
            if (pushFull || popEmpty) begin
                errReg <= 1'b1;
            end
        end
    end

    assign bus.STK_FULL  = fullReg;
    assign bus.STK_EMPTY = emptyReg;
    assign bus.STK_ERR   = errReg;
`else
    // Without a stack, RET still outranks CALL but degrades to increment.
    always_comb begin
        nextPc = pcPlus1;
        if (bus.EN_L) begin
            nextPc = pcReg;
        end else if (bus.RET) begin
            nextPc = pcPlus1;
        end else if (bus.CALL || bus.JMP) begin
            nextPc = bus.JMP_ADDR;
        end else if (bus.BR_TAKE) begin
            nextPc = pcBranch;
        end
    end

    assign bus.STK_FULL  = 1'b0;
    assign bus.STK_EMPTY = 1'b1;
    assign bus.STK_ERR   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            pcReg <= RESET_VEC;
        end else begin
            pcReg <= nextPc;
        end
    end

    assign bus.PC     = pcReg;
    assign bus.NextPC = nextPc;

endmodule
